fragment_shader: RTL and testbench

Per-fragment back end of the 3D pipeline, directly downstream of the rasterizer. It accepts one covered pixel at a time: frame-buffer address, three vertex colours, barycentric weights w1/w2 and interpolated depth. It interpolates RGB, performs a read-compare-write depth test against the packed colour/depth word at that address, and writes the result to memory through a waitrequest-style master port.

---
 rtl/fragment_shader_if.sv | 23 ++
 rtl/fragment_shader.sv | 144 ++++++++++++++
 tb/tb_fragment_shader.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fragment_shader_if.sv
// Memory bus of the fragment shader: waitrequest-style read/write master with a
// read-data strobe; the packed word is {depth[31:0], 8'h00, rgb[23:0]}.
interface fragment_shader_if #(
  parameter int unsigned ADDR_W = 26
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [63:0]       mem_writedata;
  logic [63:0]       mem_readdata;
  logic              mem_readdatavalid;
  logic              mem_waitrequest;

  modport master (
    output mem_addr, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_readdatavalid, mem_waitrequest
  );

  modport slave (
    input  mem_addr, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_readdatavalid, mem_waitrequest
  );
endinterface

// File: rtl/fragment_shader.sv
// Per-fragment back end: barycentric RGB interpolation, optional read-compare-write
// depth test against the stored word, and write-back over the memory master port.
module fragment_shader #(
  parameter bit          DEPTH_TEST = 1'b1,
  parameter int unsigned ADDR_W     = 26
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [23:0]       in_color1,
  input  logic [23:0]       in_color2,
  input  logic [23:0]       in_color3,
  input  logic [31:0]       in_w1,
  input  logic [31:0]       in_w2,
  input  logic [31:0]       in_depth,
  input  logic              in_valid,
  input  logic              done_in,
  output logic              stall_out,
  output logic              done_out,
  fragment_shader_if.master mem,
  output logic [31:0]       frag_count,
  output logic [31:0]       write_count
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_SUM, S_RD, S_RD_WAIT, S_CMP, S_WR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       col_q [3];
  logic [31:0]       w1_q, w2_q, depth_q, stored_q;
  logic [40:0]       prod_q [3][3];
  logic [40:0]       prod_d [3][3];
  logic [23:0]       rgb_q, rgb_d;
  logic [31:0]       frag_count_q, write_count_q;
  logic              done_q, done_d;
  logic              accept, wr_done;
  logic [31:0]       w3;
  logic [31:0]       wt [3];
  logic [42:0]       sum [3];
  logic              unused_rdata;

  assign unused_rdata = ^mem.mem_readdata[31:0];

  // Products are taken modulo 2^41; the true signed product always fits in 40 bits.
  always_comb begin
    w3    = 32'h0001_0000 - w1_q - w2_q;
    wt[0] = w1_q;
    wt[1] = w2_q;
    wt[2] = w3;
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 3; k++) begin
        prod_d[ch][k] = {{9{wt[k][31]}}, wt[k]} * {33'd0, col_q[k][8*ch +: 8]};
      end
    end
  end

  always_comb begin
    rgb_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum[ch] = {{2{prod_q[ch][0][40]}}, prod_q[ch][0]} +
                {{2{prod_q[ch][1][40]}}, prod_q[ch][1]} +
                {{2{prod_q[ch][2][40]}}, prod_q[ch][2]} + 43'd32768;
      if (sum[ch][42]) begin
        rgb_d[8*ch +: 8] = 8'h00;
      end else if (|sum[ch][41:24]) begin
        rgb_d[8*ch +: 8] = 8'hFF;
      end else begin
        rgb_d[8*ch +: 8] = sum[ch][23:16];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    wr_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_MUL;
        end
      end
      S_MUL:     state_d = S_SUM;
      S_SUM:     state_d = DEPTH_TEST ? S_RD : S_WR;
      S_RD:      if (!mem.mem_waitrequest) state_d = S_RD_WAIT;
      S_RD_WAIT: if (mem.mem_readdatavalid) state_d = S_CMP;
      S_CMP:     state_d = ($signed(depth_q) < $signed(stored_q)) ? S_WR : S_IDLE;
      S_WR: begin
        if (!mem.mem_waitrequest) begin
          wr_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
    done_d = done_in && (state_q == S_IDLE) && !in_valid;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      col_q         <= '{default: '0};
      w1_q          <= '0;
      w2_q          <= '0;
      depth_q       <= '0;
      stored_q      <= '0;
      prod_q        <= '{default: '{default: '0}};
      rgb_q         <= '0;
      frag_count_q  <= '0;
      write_count_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        addr_q       <= in_addr;
        col_q[0]     <= in_color1;
        col_q[1]     <= in_color2;
        col_q[2]     <= in_color3;
        w1_q         <= in_w1;
        w2_q         <= in_w2;
        depth_q      <= in_depth;
        frag_count_q <= frag_count_q + 32'd1;
      end
      if (state_q == S_MUL) prod_q <= prod_d;
      if (state_q == S_SUM) rgb_q <= rgb_d;
      if (state_q == S_RD_WAIT && mem.mem_readdatavalid) stored_q <= mem.mem_readdata[63:32];
      if (wr_done) write_count_q <= write_count_q + 32'd1;
    end
  end

  // Every output is decoded from registers only, so nothing upstream sees a comb path.
  assign stall_out         = (state_q != S_IDLE);
  assign done_out          = done_q;
  assign mem.mem_read      = (state_q == S_RD);
  assign mem.mem_write     = (state_q == S_WR);
  assign mem.mem_addr      = addr_q;
  assign mem.mem_writedata = {depth_q, 8'h00, rgb_q};
  assign frag_count        = frag_count_q;
  assign write_count       = write_count_q;

endmodule

// File: tb/tb_fragment_shader.sv
// Bench for fragment_shader: one depth-tested and one unconditional instance, a
// waitrequest memory responder, and an integer-arithmetic colour/depth reference.
module tb_fragment_shader;
  localparam int unsigned AW = 26;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] in_addr;
  logic [23:0]   in_color1, in_color2, in_color3;
  logic [31:0]   in_w1, in_w2, in_depth;
  logic          in_valid1, in_valid0, done_in;
  logic          stall1, stall0, done1, done0;
  logic [31:0]   fc1, wc1, fc0, wc0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_fc1 = 0, exp_wc1 = 0, exp_fc0 = 0, exp_wc0 = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fragment_shader_if #(.ADDR_W(AW)) m1 ();
  fragment_shader_if #(.ADDR_W(AW)) m0 ();

  fragment_shader #(.DEPTH_TEST(1'b1), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .in_addr(in_addr), .in_color1(in_color1),
    .in_color2(in_color2), .in_color3(in_color3), .in_w1(in_w1), .in_w2(in_w2),
    .in_depth(in_depth), .in_valid(in_valid1), .done_in(done_in), .stall_out(stall1),
    .done_out(done1), .mem(m1), .frag_count(fc1), .write_count(wc1)
  );

  fragment_shader #(.DEPTH_TEST(1'b0), .ADDR_W(AW)) dut0 (
    .clock(clock), .reset(reset), .in_addr(in_addr), .in_color1(in_color1),
    .in_color2(in_color2), .in_color3(in_color3), .in_w1(in_w1), .in_w2(in_w2),
    .in_depth(in_depth), .in_valid(in_valid0), .done_in(done_in), .stall_out(stall0),
    .done_out(done0), .mem(m0), .frag_count(fc0), .write_count(wc0)
  );

  // Memory responder for the depth-tested instance, acting on negedges.
  int            rd_ws = 0, wr_ws = 0, rd_lat = 0;
  int            wcnt = 0, lat_cnt = 0, held_cnt = 0, stab_err = 0;
  bit            rd_pend = 0, held = 0;
  logic [63:0]   rd_buf, snap_data;
  logic [AW-1:0] snap_addr;
  logic          snap_rd, snap_wr;
  logic [63:0]   mem1 [int unsigned];
  logic [AW-1:0] wlog1_addr [$];
  logic [63:0]   wlog1_data [$];
  int            wlog1_cyc [$];
  logic [AW-1:0] wlog0_addr [$];
  logic [63:0]   wlog0_data [$];
  int            wlog0_cyc [$];
  int            model_depth [int unsigned];

  initial begin
    m0.mem_readdata      = 64'h0;
    m0.mem_readdatavalid = 1'b0;
    m0.mem_waitrequest   = 1'b0;
  end

  always @(negedge clock) begin
    if (!reset) begin
      m1.mem_readdatavalid = 1'b0;
      m1.mem_waitrequest   = 1'b0;
      rd_pend = 0; wcnt = 0; held = 0;
    end else begin
      m1.mem_readdatavalid = 1'b0;
      if (rd_pend) begin
        if (lat_cnt > 0) lat_cnt--;
        else begin
          m1.mem_readdatavalid = 1'b1;
          m1.mem_readdata      = rd_buf;
          rd_pend              = 0;
        end
      end
      if (held && (m1.mem_addr !== snap_addr || m1.mem_writedata !== snap_data ||
                   m1.mem_read !== snap_rd || m1.mem_write !== snap_wr)) stab_err++;
      if (m1.mem_read || m1.mem_write) begin
        if (stall1 !== 1'b1) stab_err++;
        if (wcnt < (m1.mem_read ? rd_ws : wr_ws)) begin
          m1.mem_waitrequest = 1'b1;
          wcnt++; held_cnt++; held = 1;
          snap_addr = m1.mem_addr; snap_data = m1.mem_writedata;
          snap_rd = m1.mem_read; snap_wr = m1.mem_write;
        end else begin
          m1.mem_waitrequest = 1'b0;
          wcnt = 0; held = 0;
          if (m1.mem_read) begin
            rd_pend = 1; lat_cnt = rd_lat;
            rd_buf = mem1.exists(32'(m1.mem_addr)) ? mem1[32'(m1.mem_addr)] : 64'h7FFF_FFFF_0000_0000;
          end else begin
            mem1[32'(m1.mem_addr)] = m1.mem_writedata;
            wlog1_addr.push_back(m1.mem_addr);
            wlog1_data.push_back(m1.mem_writedata);
            wlog1_cyc.push_back(cyc);
          end
        end
      end else begin
        m1.mem_waitrequest = 1'b0;
        wcnt = 0; held = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset && m0.mem_write) begin
      wlog0_addr.push_back(m0.mem_addr);
      wlog0_data.push_back(m0.mem_writedata);
      wlog0_cyc.push_back(cyc);
    end
  end

  // Reference colour: weights are Q16.16, rounding by +0.5 then floor, clamped to 0..255.
  function automatic logic [23:0] model_rgb(input logic [23:0] c1, input logic [23:0] c2,
                                            input logic [23:0] c3, input int w1, input int w2);
    int w3;
    longint s, v;
    logic [23:0] r;
    w3 = 65536 - w1 - w2;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = longint'(w1) * longint'((c1 >> (8 * ch)) & 24'hFF) +
          longint'(w2) * longint'((c2 >> (8 * ch)) & 24'hFF) +
          longint'(w3) * longint'((c3 >> (8 * ch)) & 24'hFF) + 64'sd32768;
      if (s < 0) v = 0;
      else if (s / 65536 > 255) v = 255;
      else v = s / 65536;
      r[8*ch +: 8] = 8'(v);
    end
    return r;
  endfunction

  task automatic send_frag(input bit sel, input logic [AW-1:0] a, input logic [23:0] c1,
                           input logic [23:0] c2, input logic [23:0] c3, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] d, output int acc);
    @(negedge clock);
    in_addr = a; in_color1 = c1; in_color2 = c2; in_color3 = c3;
    in_w1 = w1; in_w2 = w2; in_depth = d;
    if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    acc = cyc;
    @(posedge clock);
    #1;
    in_valid1 = 1'b0;
    in_valid0 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    @(negedge clock);
    while ((sel ? stall1 : stall0) !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL wait_idle: stall_out=%b after %0d cycles, required 0", sel ? stall1 : stall0, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid1 = 0; in_valid0 = 0; done_in = 0;
    in_addr = '0; in_color1 = '0; in_color2 = '0; in_color3 = '0;
    in_w1 = '0; in_w2 = '0; in_depth = '0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({stall1, done1, m1.mem_read, m1.mem_write} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_strobes1: got %b required 0000", {stall1, done1, m1.mem_read, m1.mem_write});
    end
    vectors++;
    if (m1.mem_addr !== '0 || m1.mem_writedata !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_bus1: addr %h data %h required 0", m1.mem_addr, m1.mem_writedata);
    end
    vectors++;
    if (fc1 !== 32'd0 || wc1 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counts1: frag %0d write %0d required 0", fc1, wc1);
    end
    vectors++;
    if ({stall0, done0, m0.mem_read, m0.mem_write} !== 4'b0 || m0.mem_addr !== '0 ||
        m0.mem_writedata !== 64'h0 || fc0 !== 32'd0 || wc0 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_all0: strobes %b addr %h data %h frag %0d write %0d required all 0",
               {stall0, done0, m0.mem_read, m0.mem_write}, m0.mem_addr, m0.mem_writedata, fc0, wc0);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_dt0_directed();
    logic [23:0] c1 [4] = '{24'hC86432, 24'h0000C8, 24'hFF0080, 24'h0000FF};
    logic [23:0] c2 [4] = '{24'h000000, 24'h000064, 24'h000000, 24'h000000};
    logic [23:0] c3 [4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};
    logic [31:0] w1 [4] = '{32'h10000, 32'h8000, 32'h20000, 32'hFFFF0000};
    logic [31:0] w2 [4] = '{32'h0, 32'h8000, 32'h0, 32'h10000};
    logic [23:0] ex [4] = '{24'hC86432, 24'h000096, 24'hFF00FF, 24'h000000};
    for (int i = 0; i < 4; i++) begin
      int acc, n0;
      logic [31:0] d;
      logic [AW-1:0] a;
      d = $urandom;
      a = AW'(32'h100 + 8 * i);
      n0 = wlog0_data.size();
      send_frag(0, a, c1[i], c2[i], c3[i], w1[i], w2[i], d, acc);
      wait_idle(0);
      exp_fc0++; exp_wc0++;
      vectors++;
      if (wlog0_data.size() !== n0 + 1) begin
        miscompares++;
        $display("FAIL dt0_dir%0d_count: %0d writes required 1", i, wlog0_data.size() - n0);
      end else begin
        vectors++;
        if (wlog0_addr[n0] !== a || wlog0_data[n0] !== {d, 8'h00, ex[i]}) begin
          miscompares++;
          $display("FAIL dt0_dir%0d_word: addr %h data %h required addr %h data %h",
                   i, wlog0_addr[n0], wlog0_data[n0], a, {d, 8'h00, ex[i]});
        end
        vectors++;
        if (wlog0_cyc[n0] - acc !== 3) begin
          miscompares++;
          $display("FAIL dt0_dir%0d_latency: %0d required 3", i, wlog0_cyc[n0] - acc);
        end
      end
      vectors++;
      if (wc0 !== 32'(exp_wc0) || fc0 !== 32'(exp_fc0)) begin
        miscompares++;
        $display("FAIL dt0_dir%0d_counts: frag %0d write %0d required %0d %0d", i, fc0, wc0, exp_fc0, exp_wc0);
      end
    end
  endtask

  task automatic test_dt0_random();
    for (int i = 0; i < 20; i++) begin
      int acc, n0, w1, w2;
      logic [23:0] c1, c2, c3, rgb;
      logic [31:0] d;
      c1 = 24'($urandom); c2 = 24'($urandom); c3 = 24'($urandom); d = $urandom;
      w1 = int'($urandom_range(0, 196608)) - 32768;
      w2 = int'($urandom_range(0, 131072)) - 32768;
      rgb = model_rgb(c1, c2, c3, w1, w2);
      n0 = wlog0_data.size();
      send_frag(0, AW'(32'h1000 + 8 * i), c1, c2, c3, w1, w2, d, acc);
      wait_idle(0);
      exp_fc0++; exp_wc0++;
      vectors++;
      if (wlog0_data.size() !== n0 + 1) begin
        miscompares++;
        $display("FAIL dt0_rand%0d_count: %0d writes required 1", i, wlog0_data.size() - n0);
      end else if (wlog0_data[n0] !== {d, 8'h00, rgb}) begin
        miscompares++;
        $display("FAIL dt0_rand%0d_word: got %h required %h", i, wlog0_data[n0], {d, 8'h00, rgb});
      end
    end
    vectors++;
    if (fc0 !== 32'(exp_fc0) || wc0 !== 32'(exp_wc0)) begin
      miscompares++;
      $display("FAIL dt0_rand_counts: frag %0d write %0d required %0d %0d", fc0, wc0, exp_fc0, exp_wc0);
    end
  endtask

  task automatic test_depth_directed();
    logic [31:0] dd [3] = '{32'h400, 32'h500, 32'hFFFFFFFF};
    bit          pw [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      int acc, n0;
      mem1[32'h300] = {32'h500, 32'h0};
      n0 = wlog1_data.size();
      send_frag(1, AW'(32'h300), 24'h123456, 24'h0, 24'h0, 32'h10000, 32'h0, dd[i], acc);
      wait_idle(1);
      exp_fc1++;
      if (pw[i]) exp_wc1++;
      vectors++;
      if (wlog1_data.size() !== n0 + int'(pw[i])) begin
        miscompares++;
        $display("FAIL depth%0d_count: %0d writes required %0d", i, wlog1_data.size() - n0, pw[i]);
      end else if (pw[i]) begin
        vectors++;
        if (wlog1_data[n0] !== {dd[i], 8'h00, 24'h123456} || wlog1_cyc[n0] - acc !== 6) begin
          miscompares++;
          $display("FAIL depth%0d_word: data %h latency %0d required %h latency 6",
                   i, wlog1_data[n0], wlog1_cyc[n0] - acc, {dd[i], 8'h00, 24'h123456});
        end
      end
      vectors++;
      if (fc1 !== 32'(exp_fc1) || wc1 !== 32'(exp_wc1)) begin
        miscompares++;
        $display("FAIL depth%0d_counts: frag %0d write %0d required %0d %0d", i, fc1, wc1, exp_fc1, exp_wc1);
      end
    end
  endtask

  task automatic test_wait_states();
    int acc, n0;
    rd_ws = 5; wr_ws = 3; rd_lat = 2; stab_err = 0; held_cnt = 0;
    mem1[32'h400] = {32'h7FFF0000, 32'h0};
    n0 = wlog1_data.size();
    send_frag(1, AW'(32'h400), 24'h0, 24'hABCDEF, 24'h0, 32'h0, 32'h10000, 32'h10, acc);
    wait_idle(1);
    exp_fc1++; exp_wc1++;
    rd_ws = 0; wr_ws = 0; rd_lat = 0;
    vectors++;
    if (stab_err !== 0 || held_cnt !== 8) begin
      miscompares++;
      $display("FAIL waits_stable: unstable %0d held %0d required 0 and 8", stab_err, held_cnt);
    end
    vectors++;
    if (wlog1_data.size() !== n0 + 1) begin
      miscompares++;
      $display("FAIL waits_count: %0d writes required 1", wlog1_data.size() - n0);
    end else if (wlog1_data[n0] !== {32'h10, 8'h00, 24'hABCDEF} || wlog1_cyc[n0] - acc !== 16) begin
      miscompares++;
      $display("FAIL waits_word: data %h latency %0d required %h latency 16",
               wlog1_data[n0], wlog1_cyc[n0] - acc, {32'h10, 8'h00, 24'hABCDEF});
    end
  endtask

  task automatic test_random_dt1();
    for (int s = 0; s < 4; s++) begin
      model_depth[32'h600 + 8 * s] = int'($urandom_range(0, 40)) - 20;
      mem1[32'h600 + 8 * s] = {32'(model_depth[32'h600 + 8 * s]), 32'h0};
    end
    stab_err = 0;
    for (int i = 0; i < 30; i++) begin
      int acc, n0, w1, w2, d;
      int unsigned a;
      logic [23:0] c1, c2, c3, rgb;
      bit pass;
      a = 32'h600 + 8 * $urandom_range(0, 3);
      c1 = 24'($urandom); c2 = 24'($urandom); c3 = 24'($urandom);
      w1 = int'($urandom_range(0, 98304)) - 16384;
      w2 = int'($urandom_range(0, 65536)) - 16384;
      d = int'($urandom_range(0, 40)) - 20;
      rd_ws = $urandom_range(0, 3); wr_ws = $urandom_range(0, 3); rd_lat = $urandom_range(0, 3);
      rgb = model_rgb(c1, c2, c3, w1, w2);
      pass = d < model_depth[a];
      n0 = wlog1_data.size();
      send_frag(1, AW'(a), c1, c2, c3, w1, w2, d, acc);
      wait_idle(1);
      exp_fc1++;
      vectors++;
      if (wlog1_data.size() !== n0 + int'(pass)) begin
        miscompares++;
        $display("FAIL rand%0d_count: %0d writes required %0d (depth %0d stored %0d)",
                 i, wlog1_data.size() - n0, pass, d, model_depth[a]);
      end else if (pass && (wlog1_addr[n0] !== AW'(a) || wlog1_data[n0] !== {d, 8'h00, rgb})) begin
        miscompares++;
        $display("FAIL rand%0d_word: addr %h data %h required %h %h", i, wlog1_addr[n0],
                 wlog1_data[n0], a, {d, 8'h00, rgb});
      end
      if (pass) begin
        exp_wc1++;
        model_depth[a] = d;
      end
    end
    rd_ws = 0; wr_ws = 0; rd_lat = 0;
    vectors++;
    if (fc1 !== 32'(exp_fc1) || wc1 !== 32'(exp_wc1) || stab_err !== 0) begin
      miscompares++;
      $display("FAIL rand_counts: frag %0d write %0d unstable %0d required %0d %0d 0",
               fc1, wc1, stab_err, exp_fc1, exp_wc1);
    end
  endtask

  task automatic test_done();
    int n = 0;
    bit early = 0;
    mem1[32'h700] = {32'h7FFFFFFF, 32'h0};
    @(negedge clock);
    in_addr = AW'(32'h700); in_color1 = 24'h010203; in_w1 = 32'h10000; in_w2 = 32'h0;
    in_depth = 32'h1; in_valid1 = 1'b1; done_in = 1'b1;
    @(posedge clock);
    #1 in_valid1 = 1'b0;
    exp_fc1++; exp_wc1++;
    @(negedge clock);
    while (stall1 !== 1'b0 && n < 100) begin
      if (done1 !== 1'b0) early = 1;
      @(negedge clock);
      n++;
    end
    vectors++;
    if (early || done1 !== 1'b0 || n >= 100) begin
      miscompares++;
      $display("FAIL done_early: done_out rose before commit (early=%b now=%b cycles %0d) required 0",
               early, done1, n);
    end
    @(negedge clock);
    vectors++;
    if (done1 !== 1'b1 || done0 !== 1'b1 || wc1 !== 32'(exp_wc1)) begin
      miscompares++;
      $display("FAIL done_rise: done %b/%b write %0d required 1/1 %0d", done1, done0, wc1, exp_wc1);
    end
    done_in = 1'b0;
    @(negedge clock);
    vectors++;
    if (done1 !== 1'b0) begin
      miscompares++;
      $display("FAIL done_fall: done_out %b required 0", done1);
    end
  endtask

  task automatic test_reset_mid_wr();
    int acc, n0, n = 0;
    wr_ws = 50;
    mem1[32'h800] = {32'h7FFFFFFF, 32'h0};
    n0 = wlog1_data.size();
    send_frag(1, AW'(32'h800), 24'hFFFFFF, 24'h0, 24'h0, 32'h10000, 32'h0, 32'h5, acc);
    while (m1.mem_write !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (m1.mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_wr_reach: mem_write %b required 1", m1.mem_write);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({stall1, done1, m1.mem_read, m1.mem_write} !== 4'b0 || m1.mem_addr !== '0 ||
        m1.mem_writedata !== 64'h0 || fc1 !== 32'd0 || wc1 !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_wr_outputs: strobes %b addr %h data %h frag %0d write %0d required all 0",
               {stall1, done1, m1.mem_read, m1.mem_write}, m1.mem_addr, m1.mem_writedata, fc1, wc1);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    wr_ws = 0;
    repeat (3) @(negedge clock);
    vectors++;
    if (stall1 !== 1'b0 || wlog1_data.size() !== n0) begin
      miscompares++;
      $display("FAIL rst_wr_discard: stall %b writes %0d required 0 and 0", stall1, wlog1_data.size() - n0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_dt0_directed();
    test_dt0_random();
    test_depth_directed();
    test_wait_states();
    test_random_dt1();
    test_done();
    test_reset_mid_wr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
